// File: rtl/pps_timebase_pkg.sv
// pps_timebase_pkg: shared state encoding and default widths for the PPS time base.
package pps_timebase_pkg;

    typedef enum logic [1:0] {
        WAIT     = 2'd0,
        RUN      = 2'd1,
        HOLDOVER = 2'd2
    } state_t;

    localparam int DEF_TICK_W = 28;
    localparam int DEF_SEC_W  = 32;

endpackage

// File: rtl/pps_edge_sync.sv
// pps_edge_sync: two-flop synchronizer plus registered rising-edge detect for an asynchronous PPS.
module pps_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic pulse
);

    logic s1, s2, s3;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            s3    <= 1'b0;
            pulse <= 1'b0;
        end else begin
            s1    <= din;
            s2    <= s1;
            s3    <= s2;
            pulse <= s2 & ~s3;
        end
    end

endmodule

// File: rtl/pps_timebase.sv
// pps_timebase: seconds/tick time base locked to PPS with period measurement, holdover and timestamp capture.
// Define PPS_TIMEBASE_SYNC_EN to accept an asynchronous or multi-cycle PPS through pps_edge_sync.
module pps_timebase
    import pps_timebase_pkg::*;
#(
    parameter int TICK_W  = DEF_TICK_W,
    parameter int SEC_W   = DEF_SEC_W,
    parameter int NOMINAL = 80000000,
    parameter int TOL     = 1000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pps,
    input  logic              capture,
    output logic [SEC_W-1:0]  ts_sec,
    output logic [TICK_W-1:0] ts_tick,
    output logic              ts_valid,
    input  logic              ts_ready,
    output logic              ts_overflow,
    output logic [TICK_W-1:0] period,
    output logic              period_valid,
    output logic              pps_early,
    output logic              pps_missing,
    output logic              locked
);

    localparam logic [TICK_W-1:0] EARLY_TH = TICK_W'(NOMINAL - TOL);
    localparam logic [TICK_W-1:0] MISS_TH  = TICK_W'(NOMINAL + TOL - 1);
    localparam logic [TICK_W-1:0] NOM_M1   = TICK_W'(NOMINAL - 1);

    if (64'(NOMINAL) + 64'(TOL) >= (64'd1 << TICK_W)) begin : g_bad_cfg
        $error("pps_timebase: NOMINAL+TOL does not fit in TICK_W bits");
    end

    logic pps_evt;

`ifdef PPS_TIMEBASE_SYNC_EN
    pps_edge_sync u_sync (
        .clk   (clk),
        .rst   (rst),
        .din   (pps),
        .pulse (pps_evt)
    );
`else
    assign pps_evt = pps;
`endif

    state_t            state, state_n;
    logic [TICK_W-1:0] tick, tick_n, tick_inc, period_n;
    logic [SEC_W-1:0]  sec, sec_n, sec_inc;
    logic              pv_n, early_n;

    assign tick_inc = tick + TICK_W'(1);
    assign sec_inc  = sec + SEC_W'(1);

    always_comb begin
        state_n  = state;
        tick_n   = tick;
        sec_n    = sec;
        period_n = period;
        pv_n     = 1'b0;
        early_n  = 1'b0;
        case (state)
            WAIT: begin
                state_n = pps_evt ? RUN : WAIT;
                tick_n  = '0;
            end
            RUN: begin
                if (pps_evt) begin
                    period_n = tick_inc;
                    pv_n     = 1'b1;
                    early_n  = tick_inc < EARLY_TH;
                    tick_n   = '0;
                    sec_n    = sec_inc;
                end else if (tick == MISS_TH) begin
                    // keep phase as if the second had rolled at NOMINAL
                    state_n = HOLDOVER;
                    tick_n  = tick - NOM_M1;
                    sec_n   = sec_inc;
                end else begin
                    tick_n = tick_inc;
                end
            end
            HOLDOVER: begin
                // a pps coinciding with a wrap still advances sec only once
                state_n = pps_evt ? RUN : HOLDOVER;
                tick_n  = (pps_evt || tick == NOM_M1) ? '0 : tick_inc;
                sec_n   = (pps_evt || tick == NOM_M1) ? sec_inc : sec;
            end
            default: begin
                state_n = WAIT;
                tick_n  = '0;
                sec_n   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= WAIT;
            tick         <= '0;
            sec          <= '0;
            period       <= '0;
            period_valid <= 1'b0;
            pps_early    <= 1'b0;
            pps_missing  <= 1'b0;
            locked       <= 1'b0;
        end else begin
            state        <= state_n;
            tick         <= tick_n;
            sec          <= sec_n;
            period       <= period_n;
            period_valid <= pv_n;
            pps_early    <= early_n;
            pps_missing  <= state_n == HOLDOVER;
            locked       <= state_n == RUN;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ts_sec      <= '0;
            ts_tick     <= '0;
            ts_valid    <= 1'b0;
            ts_overflow <= 1'b0;
        end else begin
            if (capture && (!ts_valid || ts_ready)) begin
                ts_sec   <= sec;
                ts_tick  <= tick;
                ts_valid <= 1'b1;
            end else if (ts_ready) begin
                ts_valid <= 1'b0;
            end
            if (capture && ts_valid && !ts_ready)
                ts_overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pps_timebase.sv
// tb_pps_timebase: scoreboard bench for pps_timebase with NOMINAL=10, TOL=2, direct pps.
module tb_pps_timebase;

    logic        clk = 1'b0;
    logic        rst, pps, capture, ts_ready;
    logic [31:0] ts_sec;
    logic [27:0] ts_tick, period;
    logic        ts_valid, ts_overflow, period_valid, pps_early, pps_missing, locked;

    pps_timebase #(.TICK_W(28), .SEC_W(32), .NOMINAL(10), .TOL(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .pps          (pps),
        .capture      (capture),
        .ts_sec       (ts_sec),
        .ts_tick      (ts_tick),
        .ts_valid     (ts_valid),
        .ts_ready     (ts_ready),
        .ts_overflow  (ts_overflow),
        .period       (period),
        .period_valid (period_valid),
        .pps_early    (pps_early),
        .pps_missing  (pps_missing),
        .locked       (locked)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    int          m_st;
    logic [27:0] m_tick, m_per;
    logic [31:0] m_sec;
    logic        m_pv, m_early, m_valid, m_ovf;
    logic [59:0] q[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_st = 0; m_tick = '0; m_sec = '0; m_per = '0;
        m_pv = 0; m_early = 0; m_valid = 0; m_ovf = 0;
        q.delete();
    endtask

    task automatic step(input logic p, input logic c, input logic r);
        logic [59:0] e;
        pps = p; capture = c; ts_ready = r;
        if (m_valid && r) begin
            if (q.size() == 0) chk("sb_underflow", 1, 0);
            else begin
                e = q.pop_front();
                chk("ts_sec", 64'(ts_sec), 64'(e[59:28]));
                chk("ts_tick", 64'(ts_tick), 64'(e[27:0]));
            end
        end
        if (c && (!m_valid || r)) begin
            q.push_back({m_sec, m_tick});
            m_valid = 1;
        end else if (c) m_ovf = 1;
        else if (r) m_valid = 0;
        m_pv = 0; m_early = 0;
        case (m_st)
            0: if (p) begin m_st = 1; m_tick = '0; end
            1: if (p) begin
                   m_per = m_tick + 1; m_pv = 1; m_early = (m_per < 8);
                   m_tick = '0; m_sec++;
               end else if (m_tick == 11) begin
                   m_st = 2; m_tick = m_tick - 9; m_sec++;
               end else m_tick++;
            default: if (p) begin
                   m_st = 1; m_tick = '0; m_sec++;
               end else if (m_tick == 9) begin
                   m_tick = '0; m_sec++;
               end else m_tick++;
        endcase
        @(posedge clk); #1;
        pps = 0; capture = 0;
        chk("locked", 64'(locked), 64'(m_st == 1));
        chk("pps_missing", 64'(pps_missing), 64'(m_st == 2));
        chk("period_valid", 64'(period_valid), 64'(m_pv));
        chk("pps_early", 64'(pps_early), 64'(m_early));
        chk("ts_valid", 64'(ts_valid), 64'(m_valid));
        chk("ts_overflow", 64'(ts_overflow), 64'(m_ovf));
        if (m_pv) chk("period", 64'(period), 64'(m_per));
    endtask

    task automatic idle(input int n, input logic r);
        repeat (n) step(0, 0, r);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_out"}, {ts_sec, ts_tick[27:0], ts_valid, ts_overflow},
            64'd0);
        chk({tag, "_stat"}, {period, period_valid, pps_early, pps_missing, locked}, 64'd0);
    endtask

    initial begin
        rst = 1; pps = 0; capture = 0; ts_ready = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_zero("reset");
        rst = 0;
        // lock: pps at cycles 5, 15, 25
        idle(5, 1);
        step(1, 0, 1);
        chk("lock_first", 64'(locked), 64'd1);
        idle(9, 1);
        step(1, 0, 1);
        chk("period_10a", 64'(period), 64'd10);
        idle(9, 1);
        step(1, 0, 1);
        chk("period_10b", 64'(period_valid), 64'd1);
        step(0, 1, 1);
        step(0, 0, 1);
        // early pps 7 cycles after the previous one
        idle(4, 1);
        step(1, 0, 1);
        chk("early_pulse", 64'(pps_early), 64'd1);
        chk("early_period", 64'(period), 64'd7);
        // capture on pps with tick=9, sec=3, consumer stalled
        idle(9, 0);
        step(1, 1, 0);
        chk("cap_pps_sec", 64'(ts_sec), 64'd3);
        chk("cap_pps_tick", 64'(ts_tick), 64'd9);
        step(0, 1, 0);
        chk("ovf_set", 64'(ts_overflow), 64'd1);
        chk("ovf_hold", 64'(ts_tick), 64'd9);
        step(0, 1, 1);
        chk("reload_valid", 64'(ts_valid), 64'd1);
        chk("reload_tick", 64'(ts_tick), 64'd1);
        idle(2, 1);
        // holdover: no pps for 20 cycles after lock
        idle(20, 1);
        chk("holdover", 64'(pps_missing), 64'd1);
        step(0, 1, 1);
        step(1, 0, 1);
        chk("relock", 64'(locked), 64'd1);
        chk("relock_nopv", 64'(period_valid), 64'd0);
        // random captures and back-pressure around regular pps
        for (int k = 0; k < 60; k++)
            step(k % 10 == 9, $urandom_range(2) == 0, 1'($urandom));
        idle(3, 1);
        chk("sb_empty", 64'(q.size()), 64'd0);
        // reset in the middle of holdover with a held timestamp
        step(0, 1, 0);
        idle(15, 0);
        chk("pre_rst_hold", 64'(pps_missing && ts_valid), 64'd1);
        #2 rst = 1;
        #1;
        chk_zero("async_rst");
        model_reset();
        @(posedge clk); #1;
        rst = 0;
        step(0, 1, 1);
        step(0, 0, 1);
        chk("wait_state", 64'(locked | pps_missing), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
